// File: rtl/ssd1306_spi_sink.sv
// ssd1306_spi_sink
//   Receive-side model of the SSD1306 4-wire SPI link. It deserializes the
//   driver pin stream, decodes the command subset the OLED drivers use, and
//   writes data bytes into a COLS*PAGES x 8 GDDRAM mirror following SSD1306
//   horizontal / vertical / page addressing.
//
// Ports
//   clk_pin, rst_n_pin     clock, asynchronous active-low reset
//   oled_d0_pin            SCLK (asynchronous, idles high)
//   oled_d1_pin            MOSI, MSB first
//   oled_cs_pin            chip select, active low
//   oled_dc_pin            0 = command byte, 1 = data byte
//   oled_res_pin           display reset, active low (synchronous soft reset)
//   rd_addr / rd_data      GDDRAM read port (page*COLS+col), 1-cycle latency
//   display_on, invert, entire_on, charge_pump, contrast, addr_mode
//                          decoded configuration state
//   frame_done             1-cycle pulse when a write wraps to the window start
module ssd1306_spi_sink #(
  parameter int unsigned COLS        = 128,
  parameter int unsigned PAGES       = 8,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic                              clk_pin,
  input  logic                              rst_n_pin,
  input  logic                              oled_d0_pin,
  input  logic                              oled_d1_pin,
  input  logic                              oled_cs_pin,
  input  logic                              oled_dc_pin,
  input  logic                              oled_res_pin,
  input  logic [$clog2(COLS*PAGES)-1:0]     rd_addr,
  output logic [7:0]                        rd_data,
  output logic                              display_on,
  output logic                              invert,
  output logic                              entire_on,
  output logic                              charge_pump,
  output logic [7:0]                        contrast,
  output logic [1:0]                        addr_mode,
  output logic                              frame_done
);

  localparam int unsigned CW    = $clog2(COLS);
  localparam int unsigned PW    = $clog2(PAGES);
  localparam int unsigned AW    = $clog2(COLS*PAGES);
  localparam int unsigned DEPTH = COLS*PAGES;

  typedef enum logic [1:0] {IDLE_CMD, ARG1, ARG2} state_e;

  // Synchronizer, bit order {res, cs, dc, mosi, sclk}; idle levels on reset.
  localparam logic [4:0] SYNC_RST = 5'b11001;
  logic [4:0] sync_q [SYNC_STAGES];
  logic       sclk_s, mosi_s, dc_s, cs_s, res_s;

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      for (int unsigned i = 0; i < SYNC_STAGES; i++) sync_q[i] <= SYNC_RST;
    end else begin
      sync_q[0] <= {oled_res_pin, oled_cs_pin, oled_dc_pin, oled_d1_pin, oled_d0_pin};
      for (int unsigned i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
    end
  end

  assign {res_s, cs_s, dc_s, mosi_s, sclk_s} = sync_q[SYNC_STAGES-1];

  // Bit receiver
  logic       sclk_prev_q, wait_cs_q, byte_rdy_q, dc_q;
  logic [2:0] cnt_q;
  logic [6:0] shift_q;
  logic [7:0] byte_q;
  logic       sclk_rise;

  assign sclk_rise = sclk_s & ~sclk_prev_q;

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      sclk_prev_q <= 1'b1;
      wait_cs_q   <= 1'b1;
      byte_rdy_q  <= 1'b0;
      dc_q        <= 1'b0;
      cnt_q       <= '0;
      shift_q     <= '0;
      byte_q      <= '0;
    end else begin
      sclk_prev_q <= sclk_s;
      byte_rdy_q  <= 1'b0;
      if (!res_s) begin
        // After a soft reset, ignore bits until CS has been seen high so a
        // byte interrupted by the reset is not resumed part-way.
        cnt_q     <= '0;
        wait_cs_q <= 1'b1;
      end else if (cs_s) begin
        cnt_q     <= '0;
        wait_cs_q <= 1'b0;
      end else if (sclk_rise && !wait_cs_q) begin
        shift_q <= {shift_q[5:0], mosi_s};
        cnt_q   <= cnt_q + 3'd1;
        if (cnt_q == 3'd7) begin
          byte_q     <= {shift_q, mosi_s};
          dc_q       <= dc_s;
          byte_rdy_q <= 1'b1;
        end
      end
    end
  end

  // Command decoder, pointers, configuration
  state_e        state_q;
  logic [7:0]    op_q;
  logic [CW-1:0] col_q, col_start_q, col_end_q;
  logic [PW-1:0] page_q, page_start_q, page_end_q;

  always_ff @(posedge clk_pin or negedge rst_n_pin) begin
    if (!rst_n_pin) begin
      state_q <= IDLE_CMD;  op_q <= '0;
      display_on <= 1'b0;  invert <= 1'b0;  entire_on <= 1'b0;  charge_pump <= 1'b0;
      contrast <= 8'h7F;  addr_mode <= 2'd2;  frame_done <= 1'b0;
      col_q <= '0;  col_start_q <= '0;  col_end_q <= CW'(COLS-1);
      page_q <= '0;  page_start_q <= '0;  page_end_q <= PW'(PAGES-1);
    end else if (!res_s) begin
      state_q <= IDLE_CMD;  op_q <= '0;
      display_on <= 1'b0;  invert <= 1'b0;  entire_on <= 1'b0;  charge_pump <= 1'b0;
      contrast <= 8'h7F;  addr_mode <= 2'd2;  frame_done <= 1'b0;
      col_q <= '0;  col_start_q <= '0;  col_end_q <= CW'(COLS-1);
      page_q <= '0;  page_start_q <= '0;  page_end_q <= PW'(PAGES-1);
    end else begin
      frame_done <= 1'b0;
      if (byte_rdy_q && dc_q) begin
        // Data always wins: a pending command is abandoned.
        state_q <= IDLE_CMD;
        case (addr_mode)
          2'd0: begin
            if (col_q == col_end_q) begin
              col_q <= col_start_q;
              if (page_q == page_end_q) begin
                page_q     <= page_start_q;
                frame_done <= 1'b1;
              end else page_q <= page_q + PW'(1);
            end else col_q <= col_q + CW'(1);
          end
          2'd1: begin
            if (page_q == page_end_q) begin
              page_q <= page_start_q;
              if (col_q == col_end_q) begin
                col_q      <= col_start_q;
                frame_done <= 1'b1;
              end else col_q <= col_q + CW'(1);
            end else page_q <= page_q + PW'(1);
          end
          default: begin
            if (col_q == col_end_q) col_q <= col_start_q;
            else                    col_q <= col_q + CW'(1);
          end
        endcase
      end else if (byte_rdy_q) begin
        case (state_q)
          IDLE_CMD: begin
            case (byte_q) inside
              8'hAE, 8'hAF: display_on <= byte_q[0];
              8'hA6, 8'hA7: invert     <= byte_q[0];
              8'hA4, 8'hA5: entire_on  <= byte_q[0];
              8'h81, 8'h20, 8'h8D, 8'h21, 8'h22,
              8'hA8, 8'hD3, 8'hD5, 8'hD9, 8'hDA, 8'hDB: begin
                op_q    <= byte_q;
                state_q <= ARG1;
              end
              [8'hB0:8'hB7]: page_q          <= byte_q[PW-1:0];
              [8'h00:8'h0F]: col_q[3:0]      <= byte_q[3:0];
              [8'h10:8'h1F]: col_q[CW-1:4]   <= byte_q[CW-5:0];
              default: ;
            endcase
          end
          ARG1: begin
            state_q <= IDLE_CMD;
            case (op_q)
              8'h81: contrast <= byte_q;
              8'h20: if (byte_q[1:0] != 2'd3) addr_mode <= byte_q[1:0];
              8'h8D: charge_pump <= byte_q[2];
              8'h21: begin
                col_start_q <= byte_q[CW-1:0];
                col_q       <= byte_q[CW-1:0];
                state_q     <= ARG2;
              end
              8'h22: begin
                page_start_q <= byte_q[PW-1:0];
                page_q       <= byte_q[PW-1:0];
                state_q      <= ARG2;
              end
              default: ;
            endcase
          end
          ARG2: begin
            state_q <= IDLE_CMD;
            if (op_q == 8'h21) col_end_q  <= byte_q[CW-1:0];
            if (op_q == 8'h22) page_end_q <= byte_q[PW-1:0];
          end
          default: state_q <= IDLE_CMD;
        endcase
      end
    end
  end

  // GDDRAM mirror: not reset; read-before-write on the same address.
  logic [7:0]    ram_q [DEPTH];
  logic          wr_en;
  logic [AW-1:0] wr_addr;

  assign wr_en   = byte_rdy_q & dc_q & res_s;
  assign wr_addr = AW'(page_q) * AW'(COLS) + AW'(col_q);

  always_ff @(posedge clk_pin) begin
    if (wr_en) ram_q[wr_addr] <= byte_q;
    rd_data <= ram_q[rd_addr];
  end

endmodule

// File: tb/tb_ssd1306_spi_sink.sv
module tb_ssd1306_spi_sink;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       sclk = 1'b1, mosi = 1'b0, cs = 1'b1, dc = 1'b0, res = 1'b1;
  logic [9:0] rd_addr = '0;
  logic [7:0] rd_data, contrast;
  logic [1:0] addr_mode;
  logic       display_on, invert, entire_on, charge_pump, frame_done;

  ssd1306_spi_sink #(.COLS(128), .PAGES(8), .SYNC_STAGES(2)) dut (
    .clk_pin(clk), .rst_n_pin(rst_n),
    .oled_d0_pin(sclk), .oled_d1_pin(mosi), .oled_cs_pin(cs),
    .oled_dc_pin(dc), .oled_res_pin(res),
    .rd_addr(rd_addr), .rd_data(rd_data),
    .display_on(display_on), .invert(invert), .entire_on(entire_on),
    .charge_pump(charge_pump), .contrast(contrast), .addr_mode(addr_mode),
    .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  localparam int K_RD = 0, K_CFG = 1, K_FD = 2;
  typedef struct {int kind; logic [31:0] exp; logic [9:0] addr;} exp_t;
  exp_t exp_q[$];

  int n_cmp = 0, n_bad = 0, fd_cnt = 0;
  logic mon_req = 1'b0, mon_pipe = 1'b0;

  function automatic logic [31:0] cfg(input logic don, inv, ent, cp,
                                      input logic [7:0] con, input logic [1:0] md);
    return {18'd0, don, inv, ent, cp, con, md};
  endfunction

  always @(posedge clk) begin
    #1;
    if (frame_done === 1'b1) fd_cnt++;
  end

  always @(posedge clk) mon_pipe <= mon_req;

  // Monitor: pops one expectation per presented response.
  always @(negedge clk) begin
    if (mon_pipe) begin
      exp_t e;
      logic [31:0] got;
      n_cmp++;
      if (exp_q.size() == 0) begin
        n_bad++;
        $display("FAIL scoreboard_empty: response with no expectation");
      end else begin
        e = exp_q.pop_front();
        case (e.kind)
          K_RD:    got = {24'd0, rd_data};
          K_CFG:   got = cfg(display_on, invert, entire_on, charge_pump, contrast, addr_mode);
          default: got = fd_cnt;
        endcase
        if (got !== e.exp) begin
          n_bad++;
          $display("FAIL %s addr=%h got=%h exp=%h",
                   e.kind == K_RD ? "rd_data" : (e.kind == K_CFG ? "config" : "frame_done_count"),
                   e.addr, got, e.exp);
        end
      end
    end
  end

  task automatic expect_val(input int kind, input logic [31:0] exp, input logic [9:0] a);
    exp_t e;
    @(negedge clk);
    rd_addr = a;
    e.kind = kind; e.exp = exp; e.addr = a;
    exp_q.push_back(e);
    mon_req = 1'b1;
    @(negedge clk);
    mon_req = 1'b0;
  endtask

  task automatic spi_bits(input logic [7:0] b, input int n, input logic isdata);
    cs = 1'b0;
    dc = isdata;
    for (int i = 0; i < n; i++) begin
      sclk = 1'b0; mosi = b[7-i]; #30;
      sclk = 1'b1; #30;
    end
  endtask

  task automatic send(input logic [7:0] b, input logic isdata);
    spi_bits(b, 8, isdata);
    cs = 1'b1; #30;
  endtask

  initial begin
    logic [7:0] init_seq [10];
    init_seq = '{8'hAE, 8'h81, 8'h7F, 8'hA6, 8'h20, 8'h00, 8'h8D, 8'h14, 8'hA4, 8'hAF};

    #23 rst_n = 1'b1;
    repeat (4) @(posedge clk);
    expect_val(K_CFG, cfg(0, 0, 0, 0, 8'h7F, 2'd2), '0);
    expect_val(K_FD, 0, '0);

    // Init stream
    foreach (init_seq[i]) send(init_seq[i], 1'b0);
    #60;
    expect_val(K_CFG, cfg(1, 0, 0, 1, 8'h7F, 2'd0), '0);

    // Full-frame fill with CS held low
    for (int i = 0; i < 1023; i++) spi_bits(8'(i), 8, 1'b1);
    #60;
    expect_val(K_FD, 0, '0);
    spi_bits(8'hFF, 8, 1'b1);
    cs = 1'b1; #60;
    expect_val(K_FD, 1, '0);
    for (int i = 0; i < 1024; i++) expect_val(K_RD, 32'(i % 256), 10'(i));
    send(8'hC3, 1'b1);
    #30;
    expect_val(K_RD, 32'hC3, 10'h000);
    expect_val(K_RD, 32'h01, 10'h001);

    // Window 0x10..0x13 x pages 2..3
    send(8'h21, 0); send(8'h10, 0); send(8'h13, 0);
    send(8'h22, 0); send(8'h02, 0); send(8'h03, 0);
    for (int k = 0; k < 7; k++) send(8'hA0 + 8'(k), 1'b1);
    expect_val(K_FD, 1, '0);
    send(8'hA7, 1'b1);
    #30;
    expect_val(K_FD, 2, '0);
    send(8'hA8, 1'b1);
    #30;
    expect_val(K_FD, 2, '0);
    expect_val(K_RD, 32'hA8, 10'h110);
    expect_val(K_RD, 32'hA1, 10'h111);
    expect_val(K_RD, 32'hA3, 10'h113);
    expect_val(K_RD, 32'hA4, 10'h190);
    expect_val(K_RD, 32'hA7, 10'h193);
    expect_val(K_RD, 32'h14, 10'h114);
    expect_val(K_RD, 32'h0F, 10'h10F);

    // Page mode with explicit page/column set
    send(8'h20, 0); send(8'h02, 0); send(8'hB3, 0); send(8'h05, 0); send(8'h12, 0);
    send(8'hAA, 1); send(8'hBB, 1);
    #30;
    expect_val(K_RD, 32'hAA, 10'h1A5);
    expect_val(K_RD, 32'hBB, 10'h1A6);
    expect_val(K_RD, 32'hA4, 10'h1A4);
    expect_val(K_FD, 2, '0);
    expect_val(K_CFG, cfg(1, 0, 0, 1, 8'h7F, 2'd2), '0);

    // Abort: partial byte discarded on CS high
    send(8'hAE, 0);
    spi_bits(8'hAF, 5, 0); cs = 1'b1; #60;
    send(8'hAE, 0);
    #30;
    expect_val(K_CFG, cfg(0, 0, 0, 1, 8'h7F, 2'd2), '0);
    spi_bits(8'h00, 5, 0); cs = 1'b1; #60;
    send(8'hAF, 0);
    #30;
    expect_val(K_CFG, cfg(1, 0, 0, 1, 8'h7F, 2'd2), '0);

    // Data byte aborts a pending 0x81
    send(8'h81, 0); send(8'h55, 1);
    send(8'hA7, 0);
    #30;
    expect_val(K_RD, 32'h55, 10'h1A7);
    expect_val(K_CFG, cfg(1, 1, 0, 1, 8'h7F, 2'd2), '0);

    // Soft reset mid-byte
    spi_bits(8'hA5, 4, 0);
    res = 1'b0;
    repeat (10) @(posedge clk);
    res = 1'b1;
    cs = 1'b1;
    #100;
    expect_val(K_CFG, cfg(0, 0, 0, 0, 8'h7F, 2'd2), '0);
    expect_val(K_RD, 32'hAA, 10'h1A5);
    send(8'h77, 1);
    #30;
    expect_val(K_RD, 32'h77, 10'h000);
    expect_val(K_RD, 32'hA1, 10'h111);

    // Asynchronous reset mid-byte
    send(8'hAF, 0); send(8'hA7, 0); send(8'h81, 0); send(8'h33, 0);
    #30;
    expect_val(K_CFG, cfg(1, 1, 0, 0, 8'h33, 2'd2), '0);
    spi_bits(8'hFF, 3, 0);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if (cfg(display_on, invert, entire_on, charge_pump, contrast, addr_mode) !== cfg(0, 0, 0, 0, 8'h7F, 2'd2)
        || frame_done !== 1'b0) begin
      n_bad++;
      $display("FAIL async_reset got=%h exp=%h",
               cfg(display_on, invert, entire_on, charge_pump, contrast, addr_mode),
               cfg(0, 0, 0, 0, 8'h7F, 2'd2));
    end
    cs = 1'b1; sclk = 1'b1;
    #40 rst_n = 1'b1;

    repeat (6) @(negedge clk);
    if (exp_q.size() != 0) begin
      n_cmp++;
      n_bad++;
      $display("FAIL scoreboard_drain: got=%0d pending exp=0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ssd1306_spi_sink.md
# ssd1306_spi_sink

Receive-side model of the SSD1306 4-wire SPI link: it deserializes the `oled_d0_pin`/`oled_d1_pin`/`oled_cs_pin`/`oled_dc_pin` stream produced by the team's OLED drivers. It decodes the command subset the drivers use and writes data bytes into an internal 1024x8 GDDRAM mirror using SSD1306 addressing rules. It sits in the verification and loopback path: on FPGA it is fed from the driver pins, and in simulation it checks frames through a read port.

## Interface
- `COLS`, default 128: columns per page; column pointer width 7 bits.
- `PAGES`, default 8: pages; page pointer width 3 bits; RAM depth is COLS*PAGES = 1024.
- `SYNC_STAGES`, default 2: synchronizer depth on all four SPI inputs and `oled_res_pin`; minimum 2.

Ports:
- `clk_pin`  in  1  sole clock for all logic.
- `rst_n_pin`  in  1  asynchronous active-low reset.
- `oled_d0_pin`  in  1  SCLK, asynchronous to `clk_pin`, idles high.
- `oled_d1_pin`  in  1  MOSI, MSB first.
- `oled_cs_pin`  in  1  chip select, active low.
- `oled_dc_pin`  in  1  0 = command byte, 1 = data byte.
- `oled_res_pin`  in  1  display reset, active low; synchronized, then acts as a synchronous soft reset.
- `rd_addr`  in  10  GDDRAM read address (page*128+col).
- `rd_data`  out  8  GDDRAM read data.
- `display_on`, `invert`, `entire_on`, `charge_pump`  out  1 each  decoded configuration state.
- `contrast`  out  8  contrast register.
- `addr_mode`  out  2  0 = horizontal, 1 = vertical, 2 = page.
- `frame_done`  out  1  one-cycle pulse when a data write wraps the pointer back to the window start.

## Operation
- Input capture: every input passes through SYNC_STAGES flops. SCLK rising edge is detected on the synchronized signal. On each rising edge with synchronized CS low, shift in MOSI (MSB first) and increment a 3-bit counter.
- On the 8th bit: latch byte and DC (DC sampled with bit 0) and raise an internal `byte_rdy` for one cycle. The counter returns to 0.
- Synchronized CS high clears the bit counter immediately; a partial byte is discarded. Pending-argument state survives CS toggles.
- Command decoding (DC = 0):
  - `0xAE`/`0xAF` set display_on to 0/1.
  - `0xA6`/`0xA7` set invert to 0/1.
  - `0xA4`/`0xA5` set entire_on to 0/1.
  - `0x81` takes 1 argument into contrast.
  - `0x20` takes 1 argument; addr_mode <= arg[1:0], and arg[1:0]==3 leaves addr_mode unchanged.
  - `0x8D` takes 1 argument; charge_pump <= arg[2].
  - `0x21` takes 2 arguments: col_start, col_end (bits [6:0]).
  - `0x22` takes 2 arguments: page_start, page_end (bits [2:0]). Both `0x21` and `0x22` also load the pointer with the start value.
  - `0xB0`-`0xB7` set page = byte[2:0].
  - `0x00`-`0x0F` set col[3:0]; `0x10`-`0x1F` set col[6:4] = byte[2:0]. These three groups are honoured in every mode.
  - `0xA8`, `0xD3`, `0xD5`, `0xD9`, `0xDA`, `0xDB` consume 1 argument that is ignored.
  - All other opcodes are single-byte no-ops.
- State machine: IDLE_CMD, ARG1, ARG2.
  - ARG1 is entered on any 1- or 2-argument opcode.
  - ARG2 is entered only for `0x21`/`0x22`.
  - A byte received in ARG1/ARG2 is an argument regardless of value.
  - A data byte (DC = 1) received in ARG1/ARG2 aborts the pending command, returns to IDLE_CMD, and is processed as data.
- Data write (DC = 1): RAM[page*128+col] <= byte, then advance the pointer.
  - Horizontal: col==col_end then col<=col_start and page steps; else col++.
  - Vertical: page==page_end then page<=page_start and col steps; else page++.
  - Stepping the outer pointer follows the same rule: at end -> start, plus `frame_done` in horizontal/vertical modes.
  - Page mode: col==col_end then col<=col_start, page unchanged, no frame_done; else col++.
- Pointers wrap modulo width; an end value below the start is not checked. The pointer simply runs to its width limit and wraps at modulo width.

## Timing
- Reset values (async `rst_n_pin` low, or synchronized `oled_res_pin` low):
  - display_on=0, invert=0, entire_on=0, charge_pump=0, contrast=0x7F, addr_mode=2, frame_done=0.
  - col=page=col_start=page_start=0, col_end=127, page_end=7.
  - FSM in IDLE_CMD, bit counter 0.
- RAM contents are not reset. rd_data is X until the location is written.
- Latency: `byte_rdy` occurs SYNC_STAGES+1 cycles after the 8th SCLK rising edge at the pin. Register outputs and the RAM write update on the next clock edge.
- rd_data is registered, 1-cycle read latency. A write and a read to the same address in the same cycle return the old data.
- SCLK high and low phases must each be at least SYNC_STAGES+1 `clk_pin` cycles. MOSI/DC must be stable for that long around the rising edge. Faster SCLK is out of spec and behaviour is undefined.
- `oled_res_pin` low mid-byte discards the byte. After release, reception resumes at the next CS-low byte.

## Test plan
- Init stream AE 81 7F A6 20 00 8D 14 A4 AF (DC=0, CS pulsed per byte) -> display_on=1, contrast=0x7F, addr_mode=0, charge_pump=1, invert=0, entire_on=0.
- After init, send 1024 data bytes of value i[7:0] with CS held low -> rd_data at addr i equals i[7:0] for all i; exactly one frame_done, on the 1024th write; the pointer returns to (0,0).
- Send 21 10 13, 22 02 03, then 9 data bytes -> addrs 0x110-0x113, 0x190-0x193, then 0x110 with frame_done after byte 8.
- Page mode: send 20 02, B3, 05, 12, then 0xAA, 0xBB -> RAM[0x1A5]=0xAA, RAM[0x1A6]=0xBB, and no frame_done.
- Abort cases:
  - CS raised after 5 bits of 0xAF, then a full 0xAE -> display_on stays 0.
  - 81 followed by a data byte 0x55 -> contrast stays 0x7F and 0x55 is written at the current pointer.
- Reset cases:
  - oled_res_pin pulsed low mid-frame -> all config/pointer outputs return to reset values; previously written RAM is preserved.
  - rst_n_pin asserted asynchronously mid-byte -> outputs reset without a clock edge.
